// File: rtl/shared_incr_scheduler.sv
// Round-robin scheduler sharing one a+1 datapath across N_REQ requesters; `SHARED_INCR_SATURATE_EN makes each pass saturate.
// Latency: accept cycle T, resp_valid at T+2 (add_one) or T+3 (add_two); one op in flight.
// Backpressure: result held in RESP until resp_ready; req_ready only asserted in IDLE.
module shared_incr_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_op,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              op_q, op_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic [WIDTH-1:0]  a_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    end

    function automatic logic [WIDTH-1:0] incr(input logic [WIDTH-1:0] v);
`ifdef SHARED_INCR_SATURATE_EN
        return (&v) ? v : v + WIDTH'(1);
`else
        return v + WIDTH'(1);
`endif
    endfunction

    // Scan from last_grant+N_REQ down to last_grant+1 so the closest requester wins last.
    always_comb begin
        logic [ID_W-1:0] idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_grant_q) + k) % N_REQ);
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    acc_d        = a_arr[grant_id];
                    op_d         = req_op[grant_id];
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = PASS1;
                end
            end
            PASS1: begin
                acc_d   = incr(acc_q);
                state_d = op_q ? PASS2 : RESP;
            end
            PASS2: begin
                acc_d   = incr(acc_q);
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            op_q         <= 1'b0;
            id_q         <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = 1'b0;
        resp_id    = '0;
        resp_data  = '0;
        busy       = (state_q != IDLE);
        if (state_q == IDLE && grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
        if (state_q == RESP) begin
            resp_valid = 1'b1;
            resp_id    = id_q;
            resp_data  = acc_q;
        end
    end

endmodule
